// File: rtl/gb_pkg.sv
// Shared types and helpers for the gather buffer.
package gb_pkg;

    // Drain side: idle, or streaming one channel per beat.
    typedef enum logic [0:0] {
        StIdle,
        StStream
    } drain_state_e;

    // Default width for the channel index and legacy select (0 reserved for "none").
    function automatic int unsigned sel_width(input int unsigned n_ch);
        return $clog2(n_ch + 1);
    endfunction

endpackage

// File: rtl/gb_bank.sv
// One storage bank: N_CH x/w words plus a filled flag per channel.
module gb_bank #(
    parameter int unsigned N_CH = 3,
    parameter int unsigned DW   = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N_CH-1:0]   wr_en,
    input  logic              clr,
    input  logic [N_CH*DW-1:0] x_in,
    input  logic [N_CH*DW-1:0] w_in,
    output logic [N_CH*DW-1:0] x_words,
    output logic [N_CH*DW-1:0] w_words,
    output logic [N_CH-1:0]   flags,
    output logic              full
);

    // Per-channel capture; a clear and a capture in the same cycle leave only the new flags set.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            x_words <= '0;
            w_words <= '0;
            flags   <= '0;
        end else begin
            for (int i = 0; i < int'(N_CH); i++) begin
                if (wr_en[i]) begin
                    x_words[i*DW +: DW] <= x_in[i*DW +: DW];
                    w_words[i*DW +: DW] <= w_in[i*DW +: DW];
                end
            end
            flags <= (clr ? '0 : flags) | wr_en;
        end
    end

    assign full = &flags;

endmodule

// File: rtl/gather_buffer.sv
// Ping-pong gather buffer: fills one bank from per-channel done strobes while
// the other bank streams out one channel per valid/ready beat.
module gather_buffer
    import gb_pkg::*;
#(
    parameter int unsigned N_CH = 3,
    parameter int unsigned DW   = 16,
    parameter int unsigned SELW = sel_width(N_CH)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N_CH*DW-1:0] x_in,
    input  logic [N_CH*DW-1:0] w_in,
    input  logic [N_CH-1:0]    done,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DW-1:0]      out_x,
    output logic [DW-1:0]      out_w,
    output logic [SELW-1:0]    out_ch,
    output logic               out_last,
    output logic               batch_ready,
    output logic               overrun,
    input  logic [SELW-1:0]    sel,
    output logic [DW-1:0]      sel_x,
    output logic [DW-1:0]      sel_w
);

    drain_state_e      state;
    logic              fill_ptr;
    logic [SELW-1:0]   idx;

    logic [N_CH*DW-1:0] bank_x [2];
    logic [N_CH*DW-1:0] bank_w [2];
    logic [N_CH-1:0]    bank_flags [2];
    logic [1:0]         bank_full;

    logic [N_CH-1:0]    fill_flags;
    logic [N_CH-1:0]    cap_flags;
    logic [N_CH-1:0]    cap_en;
    logic [N_CH-1:0]    wr_en0;
    logic [N_CH-1:0]    wr_en1;
    logic               full;
    logic               beat_last;
    logic               swap;
    logic               cap_bank;
    logic               ovr_hit;
    logic [N_CH*DW-1:0] drain_x;
    logic [N_CH*DW-1:0] drain_w;

    assign fill_flags = fill_ptr ? bank_flags[1] : bank_flags[0];
    assign full       = fill_ptr ? bank_full[1] : bank_full[0];
    assign drain_x    = fill_ptr ? bank_x[0] : bank_x[1];
    assign drain_w    = fill_ptr ? bank_w[0] : bank_w[1];

    assign beat_last = (state == StStream) && (idx == SELW'(N_CH - 1));
    assign swap      = full && ((state == StIdle) || (out_ready && beat_last));

    // In the swap cycle the capture targets the bank being cleared, so its flags count as empty.
    assign cap_bank  = fill_ptr ^ swap;
    assign cap_flags = swap ? '0 : fill_flags;
    assign cap_en    = done & ~cap_flags;
    assign ovr_hit   = |(done & cap_flags);
    assign wr_en0    = cap_bank ? '0 : cap_en;
    assign wr_en1    = cap_bank ? cap_en : '0;

    gb_bank #(
        .N_CH (N_CH),
        .DW   (DW)
    ) u_bank0 (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_en0),
        .clr     (swap & fill_ptr),
        .x_in    (x_in),
        .w_in    (w_in),
        .x_words (bank_x[0]),
        .w_words (bank_w[0]),
        .flags   (bank_flags[0]),
        .full    (bank_full[0])
    );

    gb_bank #(
        .N_CH (N_CH),
        .DW   (DW)
    ) u_bank1 (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_en1),
        .clr     (swap & ~fill_ptr),
        .x_in    (x_in),
        .w_in    (w_in),
        .x_words (bank_x[1]),
        .w_words (bank_w[1]),
        .flags   (bank_flags[1]),
        .full    (bank_full[1])
    );

    // Drain FSM, bank swap, batch pulse and sticky overrun.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= StIdle;
            idx         <= '0;
            fill_ptr    <= 1'b0;
            batch_ready <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            batch_ready <= swap;
            overrun     <= overrun | ovr_hit;
            if (swap) begin
                fill_ptr <= ~fill_ptr;
                state    <= StStream;
                idx      <= '0;
            end else if (state == StStream && out_ready) begin
                if (beat_last) begin
                    state <= StIdle;
                    idx   <= '0;
                end else begin
                    idx <= idx + SELW'(1);
                end
            end
        end
    end

    assign out_valid = (state == StStream);
    assign out_ch    = out_valid ? idx : '0;
    assign out_last  = beat_last;

    // Beat data and legacy read port, both from the drain bank; zero when not selected.
    always_comb begin
        out_x = '0;
        out_w = '0;
        sel_x = '0;
        sel_w = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            if (out_valid && idx == SELW'(i)) begin
                out_x = drain_x[i*DW +: DW];
                out_w = drain_w[i*DW +: DW];
            end
            if (sel == SELW'(i + 1)) begin
                sel_x = drain_x[i*DW +: DW];
                sel_w = drain_w[i*DW +: DW];
            end
        end
    end

endmodule

// File: tb/tb_gather_buffer.sv
// Directed bench for gather_buffer (N_CH=3, DW=16).
module tb_gather_buffer;

    localparam int N_CH = 3;
    localparam int DW   = 16;
    localparam int SELW = 2;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [N_CH*DW-1:0] x_in;
    logic [N_CH*DW-1:0] w_in;
    logic [N_CH-1:0]    done;
    logic               out_valid;
    logic               out_ready;
    logic [DW-1:0]      out_x;
    logic [DW-1:0]      out_w;
    logic [SELW-1:0]    out_ch;
    logic               out_last;
    logic               batch_ready;
    logic               overrun;
    logic [SELW-1:0]    sel;
    logic [DW-1:0]      sel_x;
    logic [DW-1:0]      sel_w;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gather_buffer #(
        .N_CH (N_CH),
        .DW   (DW),
        .SELW (SELW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .x_in        (x_in),
        .w_in        (w_in),
        .done        (done),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_x       (out_x),
        .out_w       (out_w),
        .out_ch      (out_ch),
        .out_last    (out_last),
        .batch_ready (batch_ready),
        .overrun     (overrun),
        .sel         (sel),
        .sel_x       (sel_x),
        .sel_w       (sel_w)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int ch, input logic [15:0] xv, input logic [15:0] wv);
        x_in[ch*DW +: DW] = xv;
        w_in[ch*DW +: DW] = wv;
        done[ch] = 1'b1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; out_ready = 1'b0; done = '0; x_in = '0; w_in = '0; sel = '0;
        tick; tick;
        n_checks++;
        if ({out_valid, batch_ready, overrun, out_last, out_ch, out_x, out_w} !== '0) begin
            n_fail++;
            $display("FAIL reset_outs: got v=%b br=%b ovr=%b last=%b ch=%0d x=%h w=%h, want all 0",
                     out_valid, batch_ready, overrun, out_last, out_ch, out_x, out_w);
        end
        reset_n = 1'b1;
        for (int s = 1; s <= 3; s++) begin
            sel = 2'(s);
            #1;
            n_checks++;
            if ({sel_x, sel_w} !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_sel%0d: got x=%h w=%h, want 0 0", s, sel_x, sel_w);
            end
        end
        sel = '0;
        tick; tick;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_staggered;
        logic [35:0] got, want;
        logic [15:0] xs [3] = '{16'h0010, 16'h0020, 16'h0030};
        out_ready = 1'b1;
        done = '0; load(2, 16'h0030, 16'h0130); tick;
        done = '0; load(0, 16'h0010, 16'h0110); tick;
        done = '0; load(1, 16'h0020, 16'h0120); tick;
        done = '0;
        n_checks++;
        if ({batch_ready, out_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL stag_pre: got br=%b v=%b, want 0 0", batch_ready, out_valid);
        end
        for (int b = 0; b < 3; b++) begin
            tick;
            got  = {out_valid, out_ch, out_last, out_x, out_w};
            want = {1'b1, 2'(b), (b == 2), xs[b], xs[b] + 16'h0100};
            n_checks++;
            if (got !== want || batch_ready !== (b == 0)) begin
                n_fail++;
                $display("FAIL stag_beat%0d: got %h br=%b, want %h br=%b", b, got, batch_ready,
                         want, (b == 0));
            end
        end
        tick;
        n_checks++;
        if ({out_valid, out_x, out_ch} !== '0) begin
            n_fail++;
            $display("FAIL stag_idle: got v=%b x=%h ch=%0d, want 0 0 0", out_valid, out_x, out_ch);
        end
    endtask

    task automatic test_backpressure;
        logic [35:0] got, want;
        out_ready = 1'b0;
        done = '0;
        for (int i = 0; i < 3; i++) load(i, 16'h0040 + 16'(i), 16'h0140 + 16'(i));
        tick; done = '0;
        tick;
        for (int k = 0; k < 4; k++) begin
            got = {out_valid, out_ch, out_last, out_x, out_w};
            n_checks++;
            if (got !== {1'b1, 2'd0, 1'b0, 16'h0040, 16'h0140}) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got %h, want %h", k, got,
                         {1'b1, 2'd0, 1'b0, 16'h0040, 16'h0140});
            end
            tick;
        end
        out_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            if (b > 0) tick;
            got  = {out_valid, out_ch, out_last, out_x, out_w};
            want = {1'b1, 2'(b), (b == 2), 16'h0040 + 16'(b), 16'h0140 + 16'(b)};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL bp_beat%0d: got %h, want %h", b, got, want);
            end
        end
        tick;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_idle: got out_valid=%b, want 0", out_valid);
        end
    endtask

    // Drain two queued batches (first one already showing ch0) and check all beats.
    task automatic test_back_to_back;
        logic [35:0] got, want;
        logic [15:0] xv;
        out_ready = 1'b0;
        done = '0;
        for (int i = 0; i < 3; i++) load(i, 16'h0050 + 16'(i), 16'h0150 + 16'(i));
        tick; done = '0;
        tick;
        for (int i = 0; i < 3; i++) load(i, 16'h0100 + 16'(i), 16'h0200 + 16'(i));
        tick; done = '0;
        n_checks++;
        if ({batch_ready, out_valid, out_ch, out_x} !== {1'b0, 1'b1, 2'd0, 16'h0050}) begin
            n_fail++;
            $display("FAIL b2b_wait: got br=%b v=%b ch=%0d x=%h, want 0 1 0 0050",
                     batch_ready, out_valid, out_ch, out_x);
        end
        out_ready = 1'b1;
        for (int b = 1; b < 6; b++) begin
            tick;
            xv   = (b < 3) ? 16'h0050 + 16'(b) : 16'h0100 + 16'(b - 3);
            got  = {out_valid, out_ch, out_last, out_x, out_w};
            want = {1'b1, 2'(b % 3), (b % 3 == 2), xv, xv + ((b < 3) ? 16'h0100 : 16'h0100)};
            n_checks++;
            if (got !== want || batch_ready !== (b == 3)) begin
                n_fail++;
                $display("FAIL b2b_beat%0d: got %h br=%b, want %h br=%b", b, got, batch_ready,
                         want, (b == 3));
            end
        end
        tick;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: got out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_overrun;
        logic [35:0] got, want;
        logic [15:0] xv;
        out_ready = 1'b0;
        done = '0;
        for (int i = 0; i < 3; i++) load(i, 16'h0060 + 16'(i), 16'h0160 + 16'(i));
        tick; done = '0;
        tick;
        for (int i = 0; i < 3; i++) load(i, 16'h0070 + 16'(i), 16'h0170 + 16'(i));
        tick; done = '0;
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_pre: got overrun=%b, want 0", overrun);
        end
        load(1, 16'hDEAD, 16'hBEEF);
        tick; done = '0;
        n_checks++;
        if (overrun !== 1'b1 || out_x !== 16'h0060) begin
            n_fail++;
            $display("FAIL ovr_set: got overrun=%b x=%h, want 1 0060", overrun, out_x);
        end
        out_ready = 1'b1;
        for (int b = 1; b < 6; b++) begin
            tick;
            xv   = (b < 3) ? 16'h0060 + 16'(b) : 16'h0070 + 16'(b - 3);
            got  = {out_valid, out_ch, out_last, out_x, out_w};
            want = {1'b1, 2'(b % 3), (b % 3 == 2), xv, xv + 16'h0100};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL ovr_beat%0d: got %h, want %h", b, got, want);
            end
        end
        tick;
        n_checks++;
        if (overrun !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_sticky: got overrun=%b v=%b, want 1 0", overrun, out_valid);
        end
    endtask

    task automatic test_reset_mid_stream;
        out_ready = 1'b0;
        done = '0;
        for (int i = 0; i < 3; i++) load(i, 16'h00A0 + 16'(i), 16'h01A0 + 16'(i));
        tick; done = '0;
        tick;
        out_ready = 1'b1;
        tick;
        n_checks++;
        if (out_ch !== 2'd1 || out_x !== 16'h00A1) begin
            n_fail++;
            $display("FAIL rms_pre: got ch=%0d x=%h, want 1 00a1", out_ch, out_x);
        end
        out_ready = 1'b0;
        reset_n = 1'b0;
        tick;
        n_checks++;
        if ({out_valid, batch_ready, overrun, out_last, out_ch, out_x, out_w} !== '0) begin
            n_fail++;
            $display("FAIL rms_outs: got v=%b br=%b ovr=%b last=%b ch=%0d x=%h, want all 0",
                     out_valid, batch_ready, overrun, out_last, out_ch, out_x);
        end
        reset_n = 1'b1;
        for (int s = 1; s <= 3; s++) begin
            sel = 2'(s);
            #1;
            n_checks++;
            if ({sel_x, sel_w} !== 32'h0) begin
                n_fail++;
                $display("FAIL rms_sel%0d: got x=%h w=%h, want 0 0", s, sel_x, sel_w);
            end
        end
        sel = '0;
        tick; tick;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rms_idle: got out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_swap_capture;
        logic [35:0] got, want;
        logic [15:0] xv;
        logic [15:0] fx [3] = '{16'h0AAA, 16'h0091, 16'h0092};
        logic [15:0] fw [3] = '{16'h0BBB, 16'h0191, 16'h0192};
        out_ready = 1'b0;
        done = '0;
        for (int i = 0; i < 3; i++) load(i, 16'h0080 + 16'(i), 16'h0180 + 16'(i));
        tick; done = '0;
        load(0, 16'h0AAA, 16'h0BBB);
        tick; done = '0;
        n_checks++;
        if ({batch_ready, overrun, out_valid, out_x} !== {1'b1, 1'b0, 1'b1, 16'h0080}) begin
            n_fail++;
            $display("FAIL swap_cap: got br=%b ovr=%b v=%b x=%h, want 1 0 1 0080",
                     batch_ready, overrun, out_valid, out_x);
        end
        for (int s = 0; s <= 3; s++) begin
            sel = 2'(s);
            #1;
            n_checks++;
            if ({sel_x, sel_w} !== ((s == 0) ? 32'h0 :
                                    {16'h007F + 16'(s), 16'h017F + 16'(s)})) begin
                n_fail++;
                $display("FAIL legacy_sel%0d: got x=%h w=%h", s, sel_x, sel_w);
            end
        end
        sel = '0;
        load(1, 16'h0091, 16'h0191);
        load(2, 16'h0092, 16'h0192);
        tick; done = '0;
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL swap_no_ovr: got overrun=%b, want 0", overrun);
        end
        out_ready = 1'b1;
        for (int b = 1; b < 6; b++) begin
            tick;
            xv   = (b < 3) ? 16'h0080 + 16'(b) : fx[b - 3];
            got  = {out_valid, out_ch, out_last, out_x, out_w};
            want = {1'b1, 2'(b % 3), (b % 3 == 2), xv,
                    (b < 3) ? 16'h0180 + 16'(b) : fw[b - 3]};
            n_checks++;
            if (got !== want || batch_ready !== (b == 3)) begin
                n_fail++;
                $display("FAIL swap_beat%0d: got %h br=%b, want %h br=%b", b, got, batch_ready,
                         want, (b == 3));
            end
        end
        tick;
        n_checks++;
        if ({out_valid, out_x} !== '0) begin
            n_fail++;
            $display("FAIL swap_idle: got v=%b x=%h, want 0 0", out_valid, out_x);
        end
    endtask

    initial begin
        test_reset;
        test_staggered;
        test_backpressure;
        test_back_to_back;
        test_overrun;
        test_reset_mid_stream;
        test_swap_capture;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
